// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), counter type and
// sync-window helpers used by the sync generator.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive count range; a sync pulse is active while the counter is inside it.
  typedef struct packed {
    cnt_t first;
    cnt_t last;
  } window_t;

  function automatic window_t make_window(input int start, input int len);
    window_t w;
    w.first = cnt_t'(start);
    w.last  = cnt_t'(start + len - 1);
    return w;
  endfunction

  function automatic logic in_window(input cnt_t c, input window_t w);
    return (c >= w.first) && (c <= w.last);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a slow square wave sampled as data.
// The delayed-sample reset value is a port so the caller decides what counts as an edge out of reset.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic d_rst_val,
  output logic pulse
);

  logic d_q, d_d;
  logic pulse_q, pulse_d;

  always_comb begin
    d_d     = d;
    pulse_d = d & ~d_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= d_rst_val;
      pulse_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator running on clk, advancing one pixel per
// rising edge of the divided pixel-rate input clk_div.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t    H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t    V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t    H_VIS      = cnt_t'(H_ACTIVE);
  localparam cnt_t    V_VIS      = cnt_t'(V_ACTIVE);
  localparam window_t H_SYNC_WIN = make_window(H_ACTIVE + H_FP, H_SYNC);
  localparam window_t V_SYNC_WIN = make_window(V_ACTIVE + V_FP, V_SYNC);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || H_SYNC < 1 || V_SYNC < 1) begin : g_timing_check
    $fatal(1, "vga_sync_gen: totals must fit the 10-bit counters and sync widths must be nonzero");
  end

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // A fresh reset treats clk_div as already high, so a high level at release is not an edge.
  rise_detect u_rise_detect (
    .clk       (clk),
    .rst       (rst),
    .d         (clk_div),
    .d_rst_val (1'b1),
    .pulse     (pix_tick)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign video_on    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync       = in_window(h_cnt_q, H_SYNC_WIN) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = in_window(v_cnt_q, V_SYNC_WIN) ? SYNC_POL : ~SYNC_POL;
  assign frame_start = pix_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: default-timing instance plus two reduced-timing instances
// (active-low and active-high sync), all compared against a pixel-count model.
module tb_vga_sync_gen;

  localparam int SHA = 16, SHFP = 4, SHS = 6, SHBP = 6;
  localparam int SVA = 10, SVFP = 2, SVS = 2, SVBP = 3;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_div = 1'b1;

  always #10 clk = ~clk;

  logic       d_pix_tick, d_hsync, d_vsync, d_video_on, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       s0_pix_tick, s0_hsync, s0_vsync, s0_video_on, s0_frame_start;
  logic [9:0] s0_x, s0_y;
  logic       s1_pix_tick, s1_hsync, s1_vsync, s1_video_on, s1_frame_start;
  logic [9:0] s1_x, s1_y;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst), .clk_div(clk_div), .pix_tick(d_pix_tick), .hsync(d_hsync),
    .vsync(d_vsync), .video_on(d_video_on), .pixel_x(d_x), .pixel_y(d_y),
    .frame_start(d_frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .SYNC_POL(1'b0)
  ) u_s0 (
    .clk(clk), .rst(rst), .clk_div(clk_div), .pix_tick(s0_pix_tick), .hsync(s0_hsync),
    .vsync(s0_vsync), .video_on(s0_video_on), .pixel_x(s0_x), .pixel_y(s0_y),
    .frame_start(s0_frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .SYNC_POL(1'b1)
  ) u_s1 (
    .clk(clk), .rst(rst), .clk_div(clk_div), .pix_tick(s1_pix_tick), .hsync(s1_hsync),
    .vsync(s1_vsync), .video_on(s1_video_on), .pixel_x(s1_x), .pixel_y(s1_y),
    .frame_start(s1_frame_start)
  );

  logic [24:0] d_vec, s0_vec, s1_vec;
  assign d_vec  = {d_pix_tick, d_frame_start, d_video_on, d_hsync, d_vsync, d_x, d_y};
  assign s0_vec = {s0_pix_tick, s0_frame_start, s0_video_on, s0_hsync, s0_vsync, s0_x, s0_y};
  assign s1_vec = {s1_pix_tick, s1_frame_start, s1_video_on, s1_hsync, s1_vsync, s1_x, s1_y};

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pixel periods elapsed since reset; screen position follows by div/mod.
  longint m_ticks = 0;
  bit     m_tick  = 1'b0;
  bit     m_prev  = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_ticks = 0;
      m_tick  = 1'b0;
      m_prev  = 1'b1;
    end else begin
      if (m_tick) m_ticks = m_ticks + 1;
      m_tick = clk_div && !m_prev;
      m_prev = clk_div;
    end
  end

  function automatic logic [24:0] exp_vec(input int ha, input int hfp, input int hs, input int hbp,
                                          input int va, input int vfp, input int vs, input int vbp,
                                          input bit pol);
    int     ht, vt, h, v;
    longint pos;
    logic   fs, von, hsy, vsy;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    pos = m_ticks % longint'(ht * vt);
    h   = int'(pos % ht);
    v   = int'(pos / ht);
    fs  = m_tick && (h == ht - 1) && (v == vt - 1);
    von = (h < ha) && (v < va);
    hsy = (h >= ha + hfp && h < ha + hfp + hs) ? pol : !pol;
    vsy = (v >= va + vfp && v < va + vfp + vs) ? pol : !pol;
    return {m_tick, fs, von, hsy, vsy, 10'(h), 10'(v)};
  endfunction

  function automatic logic [74:0] exp_all();
    return {exp_vec(640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            exp_vec(SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, 1'b0),
            exp_vec(SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, 1'b1)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clk_div = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_div = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (d_vec !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
      n_bad++;
      $display("FAIL reset_def got=%h want=%h", d_vec, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'd0});
    end
    n_cmp++;
    if ({s1_hsync, s1_vsync, s1_video_on, s1_x, s1_y} !== {1'b0, 1'b0, 1'b1, 20'd0}) begin
      n_bad++;
      $display("FAIL reset_pol1 got hs=%b vs=%b von=%b x=%0d y=%0d want hs=0 vs=0 von=1 x=0 y=0",
               s1_hsync, s1_vsync, s1_video_on, s1_x, s1_y);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({d_vec, s0_vec, s1_vec} !== exp_all() || d_pix_tick !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release got=%h want=%h", {d_vec, s0_vec, s1_vec}, exp_all());
      end
    end
  endtask

  task automatic test_line_default();
    int cyc = 0, c1 = -1, c2 = -1, last_tick = -1, bad_iv = 0;
    int hs_low = 0, hs_first = -1;
    bit wrap_ok = 1'b0, wrap_seen = 1'b0;
    logic [9:0] px = 0, py = 0;
    do_reset();
    while (cyc < 4000 && c2 < 0) begin
      @(negedge clk);
      n_cmp++;
      if ({d_vec, s0_vec, s1_vec} !== exp_all()) begin
        n_bad++;
        $display("FAIL line_model cyc=%0d got=%h want=%h", cyc, {d_vec, s0_vec, s1_vec}, exp_all());
      end
      if (d_pix_tick) begin
        if (last_tick >= 0 && cyc - last_tick != 2) bad_iv++;
        last_tick = cyc;
        if (d_y == 0 && d_hsync == 1'b0) begin
          if (hs_first < 0) hs_first = int'(d_x);
          hs_low++;
        end
      end
      if (px == 10'd799 && py == 10'd0 && d_x != px) begin
        wrap_seen = 1'b1;
        wrap_ok = (d_x == 10'd0) && (d_y == 10'd1);
      end
      if (d_x == 10'd1 && d_y == 10'd0 && c1 < 0) c1 = cyc;
      if (d_x == 10'd1 && d_y == 10'd1 && c2 < 0) c2 = cyc;
      px = d_x;
      py = d_y;
      clk_div = ~clk_div;
      cyc++;
    end
    n_cmp++;
    if (c1 < 0 || c2 < 0 || c2 - c1 != 1600) begin
      n_bad++;
      $display("FAIL line_length got=%0d clk want=1600 (c1=%0d c2=%0d)", c2 - c1, c1, c2);
    end
    n_cmp++;
    if (bad_iv != 0) begin
      n_bad++;
      $display("FAIL tick_interval got %0d irregular gaps want 0", bad_iv);
    end
    n_cmp++;
    if (!(wrap_seen && wrap_ok)) begin
      n_bad++;
      $display("FAIL h_wrap got seen=%0b ok=%0b want seen=1 ok=1", wrap_seen, wrap_ok);
    end
    n_cmp++;
    if (hs_low != 96 || hs_first != 656) begin
      n_bad++;
      $display("FAIL hsync_window got len=%0d start=%0d want len=96 start=656", hs_low, hs_first);
    end
  endtask

  task automatic test_stall();
    int cyc = 0;
    bit found = 1'b0;
    do_reset();
    while (cyc < 2000 && !found) begin
      @(negedge clk);
      n_cmp++;
      if ({d_vec, s0_vec, s1_vec} !== exp_all()) begin
        n_bad++;
        $display("FAIL stall_lead got=%h want=%h", {d_vec, s0_vec, s1_vec}, exp_all());
      end
      if (d_x == 10'd299 && clk_div == 1'b0) found = 1'b1;
      else clk_div = ~clk_div;
      cyc++;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL stall_reach got x=%0d want x=299 within budget", d_x);
    end
    clk_div = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (d_x !== 10'd300 || d_pix_tick !== 1'b0 || {d_vec, s0_vec, s1_vec} !== exp_all()) begin
        n_bad++;
        $display("FAIL stall_hold i=%0d got x=%0d tick=%b want x=300 tick=0", i, d_x, d_pix_tick);
      end
    end
    clk_div = 1'b0;
    @(negedge clk);
    clk_div = 1'b1;
    for (int i = 0; i < 6 && d_x == 10'd300; i++) @(negedge clk);
    n_cmp++;
    if (d_x !== 10'd301 || {d_vec, s0_vec, s1_vec} !== exp_all()) begin
      n_bad++;
      $display("FAIL stall_resume got x=%0d want x=301", d_x);
    end
  endtask

  task automatic test_frame_small();
    int cyc = 0, nfs = 0, ticks = 0, von = 0, hs_low = 0, hs_start = 0, vs_low = 0, vs_bad = 0;
    int hs1_high = 0, vs1_high = 0;
    bit in_win = 1'b0;
    do_reset();
    while (cyc < 5000 && nfs < 2) begin
      @(negedge clk);
      n_cmp++;
      if ({d_vec, s0_vec, s1_vec} !== exp_all()) begin
        n_bad++;
        $display("FAIL frame_model cyc=%0d got=%h want=%h", cyc, {d_vec, s0_vec, s1_vec}, exp_all());
      end
      if (s0_pix_tick && in_win) begin
        ticks++;
        if (s0_video_on) von++;
        if (!s0_hsync) begin
          hs_low++;
          if (s0_x == 10'(SHA + SHFP)) hs_start++;
        end
        if (!s0_vsync) begin
          vs_low++;
          if (s0_y < 10'(SVA + SVFP) || s0_y >= 10'(SVA + SVFP + SVS)) vs_bad++;
        end
        if (s1_hsync) hs1_high++;
        if (s1_vsync) vs1_high++;
      end
      if (s0_frame_start) begin
        nfs++;
        in_win = (nfs == 1);
      end
      clk_div = ~clk_div;
      cyc++;
    end
    n_cmp++;
    if (nfs != 2 || ticks != SHT * SVT) begin
      n_bad++;
      $display("FAIL frame_period got fs=%0d ticks=%0d want fs=2 ticks=%0d", nfs, ticks, SHT * SVT);
    end
    n_cmp++;
    if (von != SHA * SVA) begin
      n_bad++;
      $display("FAIL video_on_count got=%0d want=%0d", von, SHA * SVA);
    end
    n_cmp++;
    if (hs_low != SHS * SVT || hs_start != SVT) begin
      n_bad++;
      $display("FAIL hsync_frame got low=%0d starts=%0d want low=%0d starts=%0d",
               hs_low, hs_start, SHS * SVT, SVT);
    end
    n_cmp++;
    if (vs_low != SVS * SHT || vs_bad != 0) begin
      n_bad++;
      $display("FAIL vsync_frame got low=%0d outside=%0d want low=%0d outside=0", vs_low, vs_bad, SVS * SHT);
    end
    n_cmp++;
    if (hs1_high != SHS * SVT || vs1_high != SVS * SHT) begin
      n_bad++;
      $display("FAIL sync_pol1 got hs_high=%0d vs_high=%0d want %0d %0d",
               hs1_high, vs1_high, SHS * SVT, SVS * SHT);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit found = 1'b0, ticked = 1'b0;
    do_reset();
    while (cyc < 3000 && !found) begin
      @(negedge clk);
      if (s0_x == 10'd28 && s0_y == 10'd13) found = 1'b1;
      else clk_div = ~clk_div;
      cyc++;
    end
    n_cmp++;
    if (!found || s0_vsync !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_reach got x=%0d y=%0d vs=%b want x=28 y=13 vs=0", s0_x, s0_y, s0_vsync);
    end
    rst = 1'b1;
    clk_div = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({s0_x, s0_y, s0_hsync, s0_vsync, s0_pix_tick, s1_hsync, s1_vsync} !==
        {20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_state got x=%0d y=%0d hs=%b vs=%b tick=%b hs1=%b vs1=%b want 0 0 1 1 0 0 0",
               s0_x, s0_y, s0_hsync, s0_vsync, s0_pix_tick, s1_hsync, s1_vsync);
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (s0_pix_tick !== 1'b0 || {d_vec, s0_vec, s1_vec} !== exp_all()) begin
        n_bad++;
        $display("FAIL midreset_notick got tick=%b x=%0d want tick=0 x=0", s0_pix_tick, s0_x);
      end
    end
    clk_div = 1'b0;
    @(negedge clk);
    clk_div = 1'b1;
    for (int i = 0; i < 4 && !ticked; i++) begin
      @(negedge clk);
      if (s0_pix_tick) ticked = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!ticked || s0_x !== 10'd1 || {d_vec, s0_vec, s1_vec} !== exp_all()) begin
      n_bad++;
      $display("FAIL midreset_resume got ticked=%0b x=%0d want ticked=1 x=1", ticked, s0_x);
    end
  endtask

  task automatic test_random_pol();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({d_vec, s0_vec, s1_vec} !== exp_all() || s1_vec !== (s0_vec ^ 25'h030_0000)) begin
        n_bad++;
        $display("FAIL random_model i=%0d got=%h want=%h", i, {d_vec, s0_vec, s1_vec}, exp_all());
      end
      clk_div = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_default();
    test_stall();
    test_frame_small();
    test_reset_mid();
    test_random_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
